// File: rtl/ps2_ctrl_pkg.sv
// Shared types and constants for the PS/2 command sequencer.
// State encoding, completion status codes and device response bytes.
package ps2_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    RELEASE,
    WAIT_RESP,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_TX_TMO   = 2'b01,
    ST_NACK     = 2'b10,
    ST_RESP_TMO = 2'b11
  } status_t;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

endpackage

// File: rtl/ps2_cmd_fifo.sv
// Synchronous byte FIFO holding queued host commands.
// Push while full is dropped; pop while empty is ignored; depth must be a power of two.
module ps2_cmd_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         wr_data,
  input  logic               push,
  input  logic               pop,
  output logic [7:0]         rd_data,
  output logic [FIFO_AW:0]   count,
  output logic               full,
  output logic               empty
);

  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == (FIFO_AW + 1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage write; contents are qualified by count, so no reset is needed.
  // NOTE: memory arrays are left unreset so they map onto plain RAM/regfile cells.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at FIFO_DEPTH; count tracks occupancy.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// PS/2 command sequencer: queues host commands, drives the transmitter handshake,
// then waits for ACK (0xFA) or RESEND (0xFE) from the device, retrying up to MAX_RETRY.
// Optional response timeout enabled by defining PS2_CMD_RESP_TIMEOUT_EN.
module ps2_cmd_sequencer
  import ps2_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2,
  parameter int MAX_RETRY  = 3
`ifdef PS2_CMD_RESP_TIMEOUT_EN
  ,
  parameter int RESP_TIMEOUT_CYCLES = 1000000,
  parameter int RESP_TIMEOUT_BITS   = 20
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         cmd_data,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  output logic [FIFO_AW:0]   fifo_count,
  output logic [7:0]         the_command,
  output logic               send_command,
  input  logic               command_was_sent,
  input  logic               error_communication_timed_out,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               busy,
  output logic               done,
  output logic [1:0]         status
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  state_t               state;
  status_t              status_q;
  logic [7:0]           cur_cmd;
  logic [RETRY_W-1:0]   retry_cnt;
  logic                 tx_err;
  logic [7:0]           fifo_rd_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
`ifdef PS2_CMD_RESP_TIMEOUT_EN
  logic [RESP_TIMEOUT_BITS-1:0] tmo_cnt;
`endif

  assign cmd_ready = !fifo_full;
  assign fifo_pop  = (state == IDLE) && !fifo_empty;
  assign busy      = (state != IDLE);
  assign status    = status_q;

  ps2_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_data (cmd_data),
    .push    (cmd_valid),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Command sequencing FSM with registered handshake, done and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      status_q     <= ST_OK;
      cur_cmd      <= '0;
      retry_cnt    <= '0;
      tx_err       <= 1'b0;
      the_command  <= '0;
      send_command <= 1'b0;
      done         <= 1'b0;
`ifdef PS2_CMD_RESP_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            cur_cmd      <= fifo_rd_data;
            the_command  <= fifo_rd_data;
            retry_cnt    <= '0;
            send_command <= 1'b1;
            state        <= SEND;
          end
        end
        SEND: begin
          // A transmitter timeout outranks a simultaneous completion flag.
          if (error_communication_timed_out) begin
            tx_err       <= 1'b1;
            send_command <= 1'b0;
            state        <= RELEASE;
          end else if (command_was_sent) begin
            tx_err       <= 1'b0;
            send_command <= 1'b0;
            state        <= RELEASE;
          end
        end
        RELEASE: begin
          // One cycle with send_command low lets the transmitter clear its flags.
          if (tx_err) begin
            status_q <= ST_TX_TMO;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
`ifdef PS2_CMD_RESP_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            state   <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (rx_valid && rx_data == PS2_ACK) begin
            status_q <= ST_OK;
            done     <= 1'b1;
            state    <= DONE;
          end else if (rx_valid && rx_data == PS2_RESEND) begin
            if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
              retry_cnt    <= retry_cnt + 1'b1;
              the_command  <= cur_cmd;
              send_command <= 1'b1;
              state        <= SEND;
            end else begin
              status_q <= ST_NACK;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
`ifdef PS2_CMD_RESP_TIMEOUT_EN
          else if (tmo_cnt == RESP_TIMEOUT_BITS'(RESP_TIMEOUT_CYCLES - 1)) begin
            status_q <= ST_RESP_TMO;
            done     <= 1'b1;
            state    <= DONE;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Self-checking bench for ps2_cmd_sequencer: transmitter/device model plus a
// scoreboard of expected (command, status, send-phase count) per queued byte.
module tb_ps2_cmd_sequencer;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = 2;
  localparam int MAX_RETRY  = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       cmd_data;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [FIFO_AW:0] fifo_count;
  logic [7:0]       the_command;
  logic             send_command;
  logic             command_was_sent;
  logic             error_communication_timed_out;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             busy;
  logic             done;
  logic [1:0]       status;

  typedef struct {
    logic [7:0] cmd;
    int         nfe;
    bit         ack;
    bit         tx_err;
    bit         silent;
    logic [1:0] st;
    int         sends;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   done_seen = 0;
  int   sends_cur = 0;
  bit   xmit_stall = 1'b0;
  bit   junk_en    = 1'b0;

  always #5 clk = ~clk;

  ps2_cmd_sequencer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW),
    .MAX_RETRY  (MAX_RETRY)
`ifdef PS2_CMD_RESP_TIMEOUT_EN
    ,
    .RESP_TIMEOUT_CYCLES (100),
    .RESP_TIMEOUT_BITS   (20)
`endif
  ) dut (
    .clk                           (clk),
    .reset                         (reset),
    .cmd_data                      (cmd_data),
    .cmd_valid                     (cmd_valid),
    .cmd_ready                     (cmd_ready),
    .fifo_count                    (fifo_count),
    .the_command                   (the_command),
    .send_command                  (send_command),
    .command_was_sent              (command_was_sent),
    .error_communication_timed_out (error_communication_timed_out),
    .rx_data                       (rx_data),
    .rx_valid                      (rx_valid),
    .busy                          (busy),
    .done                          (done),
    .status                        (status)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Expected outcome of one command given how the device/transmitter will behave.
  function automatic exp_t mk(input logic [7:0] c, input int nfe, input bit ack,
                              input bit tx_err, input bit silent);
    exp_t e;
    e.cmd = c; e.nfe = nfe; e.ack = ack; e.tx_err = tx_err; e.silent = silent;
    if (tx_err) begin
      e.st = 2'b01; e.sends = 1;
    end else if (silent) begin
      e.st = 2'b11; e.sends = 1;
    end else if (ack && nfe <= MAX_RETRY) begin
      e.st = 2'b00; e.sends = nfe + 1;
    end else begin
      e.st = 2'b10; e.sends = MAX_RETRY + 1;
    end
    return e;
  endfunction

  // One push attempt; the bench states whether it should be accepted.
  task automatic push(input logic [7:0] b, input exp_t e, input bit accept);
    cmd_data  = b;
    cmd_valid = 1'b1;
    check($sformatf("cmd_ready_%02h", b), {31'd0, cmd_ready}, {31'd0, accept});
    if (accept) exp_q.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_seen < target; i++) begin
      @(posedge clk); #1;
    end
    check($sformatf("done_reached_%0d", target), {31'd0, done_seen >= target}, 32'd1);
  endtask

  task automatic wait_send(input int budget);
    for (int i = 0; i < budget && !send_command; i++) begin
      @(posedge clk); #1;
    end
    check("send_seen", {31'd0, send_command}, 32'd1);
  endtask

  // Transmitter, device and done monitor, evaluated 1 time unit after each edge.
  initial begin : env
    exp_t e;
    int   tx_cnt = 0, resp_wait = 0, resp_idx = 0;
    int   cyc = 0, fall_cyc = 0, resp_cyc = 0;
    bit   prev_send = 1'b0;
    e = mk(8'h00, 0, 1'b1, 1'b0, 1'b0);
    forever begin
      @(posedge clk); #1;
      cyc++;
      rx_valid = 1'b0;
      if (reset) begin
        command_was_sent = 1'b0;
        error_communication_timed_out = 1'b0;
        prev_send = 1'b0; tx_cnt = 0; resp_wait = 0; resp_idx = 0; sends_cur = 0;
      end else begin
        if (done) begin
          if (exp_q.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("status_%02h", e.cmd), {30'd0, status}, {30'd0, e.st});
            check($sformatf("sends_%02h", e.cmd), sends_cur, e.sends);
            if (e.tx_err) check("done_lat_tx", cyc - fall_cyc, 1);
            else if (e.silent) check("done_lat_tmo", cyc - fall_cyc, 101);
            else check("done_lat_rx", cyc - resp_cyc, 1);
          end
          sends_cur = 0; resp_idx = 0; done_seen++;
        end
        if (exp_q.size() > 0) e = exp_q[0];
        if (send_command) begin
          if (!prev_send) begin
            sends_cur++;
            tx_cnt = 0;
            if (exp_q.size() == 0) check("send_without_cmd", 32'd1, 32'd0);
            else check("the_command", {24'd0, the_command}, {24'd0, e.cmd});
          end
          tx_cnt++;
          if (!xmit_stall && tx_cnt >= 2) begin
            if (e.tx_err) error_communication_timed_out = 1'b1;
            else command_was_sent = 1'b1;
          end
        end else begin
          if (prev_send) begin
            fall_cyc = cyc;
            if (!e.tx_err && !e.silent) resp_wait = 3;
          end
          command_was_sent = 1'b0;
          error_communication_timed_out = 1'b0;
        end
        prev_send = send_command;
        if (resp_wait > 0) begin
          resp_wait--;
          if (resp_wait == 1 && junk_en) begin
            rx_valid = 1'b1;
            rx_data  = 8'h12;
          end else if (resp_wait == 0) begin
            rx_valid = 1'b1;
            rx_data  = (resp_idx < e.nfe || !e.ack) ? 8'hFE : 8'hFA;
            resp_idx++;
            resp_cyc = cyc;
          end
        end
      end
    end
  end

  initial begin : stim
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_data = 8'h00;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    command_was_sent = 1'b0;
    error_communication_timed_out = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_send_command", {31'd0, send_command}, 32'd0);
    check("rst_the_command", {24'd0, the_command}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_status", {30'd0, status}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // ACK on first try, with an unrelated byte ahead of it; checks push-to-send latency.
    junk_en = 1'b1;
    push(8'hFF, mk(8'hFF, 0, 1'b1, 1'b0, 1'b0), 1'b1);
    check("lat_first_cycle", {31'd0, send_command}, 32'd0);
    @(posedge clk); #1;
    check("lat_send_high", {31'd0, send_command}, 32'd1);
    check("busy_in_send", {31'd0, busy}, 32'd1);
    wait_done(1, 200);
    junk_en = 1'b0;

    // Two RESENDs then ACK.
    push(8'hF4, mk(8'hF4, 2, 1'b1, 1'b0, 1'b0), 1'b1);
    wait_done(2, 300);

    // RESEND on every attempt: retries exhausted.
    push(8'hED, mk(8'hED, 0, 1'b0, 1'b0, 1'b0), 1'b1);
    wait_done(3, 400);

    // Transmitter timeout.
    push(8'hF2, mk(8'hF2, 0, 1'b1, 1'b1, 1'b0), 1'b1);
    wait_done(4, 200);
    repeat (3) @(posedge clk);
    #1;
    check("status_held", {30'd0, status}, 32'd1);
    check("idle_after_done", {31'd0, busy}, 32'd0);

    // Fill the queue behind a stalled command; the fifth push must be refused.
    xmit_stall = 1'b1;
    push(8'hF3, mk(8'hF3, 0, 1'b1, 1'b0, 1'b0), 1'b1);
    for (int i = 0; i < 4; i++) begin
      push(8'hA0 + 8'(i), mk(8'hA0 + 8'(i), i % 2, 1'b1, 1'b0, 1'b0), 1'b1);
    end
    check("full_count", {29'd0, fifo_count}, 32'd4);
    push(8'hA4, mk(8'hA4, 0, 1'b1, 1'b0, 1'b0), 1'b0);
    check("full_no_overwrite", {29'd0, fifo_count}, 32'd4);
    xmit_stall = 1'b0;
    wait_done(9, 3000);

    // Reset in the middle of SEND with one entry still queued.
    xmit_stall = 1'b1;
    push(8'hE6, mk(8'hE6, 0, 1'b1, 1'b0, 1'b0), 1'b1);
    push(8'hE8, mk(8'hE8, 0, 1'b1, 1'b0, 1'b0), 1'b1);
    wait_send(20);
    check("pre_reset_count", {29'd0, fifo_count}, 32'd1);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("mid_rst_send_command", {31'd0, send_command}, 32'd0);
    check("mid_rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    xmit_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", {31'd0, send_command}, 32'd0);

    // Normal operation resumes after reset.
    push(8'hF5, mk(8'hF5, 1, 1'b1, 1'b0, 1'b0), 1'b1);
    wait_done(10, 300);

`ifdef PS2_CMD_RESP_TIMEOUT_EN
    // Silent device: response timeout after 100 cycles in WAIT_RESP.
    push(8'hF0, mk(8'hF0, 0, 1'b1, 1'b0, 1'b1), 1'b1);
    wait_done(11, 500);
`endif

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
